// File: rtl/learn_step_scheduler.sv
// Learning-play sequencer: steps song ROM notes, times note and gap windows, grades key hits into a saturating score.
// Optional LEARN_WAIT_EN: an unhit gap parks in WAIT until the correct key arrives instead of scoring a Miss.
module learn_step_scheduler #(
  parameter int unsigned TICK_DIV  = 100000,
  parameter int unsigned GAP_TICKS = 100,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned DUR_W     = 16,
  parameter int unsigned SCORE_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [3:0]         rom_note,
  input  logic [DUR_W-1:0]   rom_dur,
  input  logic               key_valid,
  input  logic [3:0]         key_note,
  output logic [3:0]         cur_note,
  output logic               note_en,
  output logic [2:0]         hit_grade,
  output logic               grade_valid,
  output logic [SCORE_W-1:0] score,
  output logic               busy,
  output logic               done
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned GAP_W = $clog2(GAP_TICKS + 1);
  localparam int unsigned CNT_W = (DUR_W > GAP_W) ? DUR_W : GAP_W;
  localparam int unsigned THR_W = CNT_W + 2;

  localparam logic [2:0] G_S    = 3'd0;
  localparam logic [2:0] G_A    = 3'd1;
  localparam logic [2:0] G_B    = 3'd2;
  localparam logic [2:0] G_C    = 3'd3;
  localparam logic [2:0] G_MISS = 3'd4;

`ifdef LEARN_WAIT_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP, S_DONE, S_WAIT} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP, S_DONE} state_e;
`endif

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic [3:0]         cur_note_q, cur_note_d;
  logic               note_en_q, note_en_d;
  logic [2:0]         hit_grade_q, hit_grade_d;
  logic               grade_valid_q, grade_valid_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               hit_q, hit_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [DUR_W-1:0]   dur_q, dur_d;

  logic               running;
  logic               tick;
  logic               key_hit;
  logic               adv;
  logic [THR_W-1:0]   e_w, q1, q2, q3;
  logic [2:0]         grade;
  logic [1:0]         pts;
  logic [SCORE_W:0]   score_sum;

  // Timing base and key qualification
  always_comb begin
    running = (state_q == S_PLAY) || (state_q == S_GAP);
`ifdef LEARN_WAIT_EN
    if (state_q == S_WAIT) running = 1'b1;
`endif
    tick    = running && (pre_q == PRE_W'(TICK_DIV - 1));
    key_hit = running && key_valid && (key_note == cur_note_q) && !hit_q;

    e_w = THR_W'(tick_cnt_q);
    q1  = THR_W'(dur_q) >> 2;
    q2  = q1 << 1;
    q3  = q1 + q2;

    grade = G_C;
    if (state_q == S_PLAY) begin
      if (e_w < q1)      grade = G_S;
      else if (e_w < q2) grade = G_A;
      else if (e_w < q3) grade = G_B;
      else               grade = G_C;
    end

    case (grade)
      G_S:     pts = 2'd3;
      G_A:     pts = 2'd2;
      G_B:     pts = 2'd1;
      default: pts = 2'd0;
    endcase
    score_sum = {1'b0, score_q} + (SCORE_W + 1)'(pts);
  end

  // Next-state and registered outputs
  always_comb begin
    state_d       = state_q;
    rom_addr_d    = rom_addr_q;
    cur_note_d    = cur_note_q;
    hit_grade_d   = hit_grade_q;
    grade_valid_d = 1'b0;
    score_d       = score_q;
    hit_d         = hit_q;
    dur_d         = dur_q;
    pre_d         = '0;
    tick_cnt_d    = '0;
    adv           = 1'b0;

    if (key_hit) begin
      hit_d         = 1'b1;
      grade_valid_d = 1'b1;
      hit_grade_d   = grade;
      score_d       = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LOAD;
          rom_addr_d = '0;
          score_d    = '0;
        end
      end
      S_LOAD: begin
        dur_d      = (rom_dur == '0) ? DUR_W'(1) : rom_dur;
        cur_note_d = rom_note;
        hit_d      = 1'b0;
        state_d    = (rom_note == 4'd0) ? S_DONE : S_PLAY;
      end
      S_PLAY: begin
        if (tick && ((tick_cnt_q + CNT_W'(1)) == CNT_W'(dur_q))) state_d = S_GAP;
      end
      S_GAP: begin
        if (tick && ((tick_cnt_q + CNT_W'(1)) == CNT_W'(GAP_TICKS))) begin
          if (hit_q || key_hit) begin
            adv = 1'b1;
          end else begin
`ifdef LEARN_WAIT_EN
            state_d = S_WAIT;
`else
            grade_valid_d = 1'b1;
            hit_grade_d   = G_MISS;
            adv           = 1'b1;
`endif
          end
        end
      end
`ifdef LEARN_WAIT_EN
      S_WAIT: begin
        if (key_hit) adv = 1'b1;
      end
`endif
      S_DONE: begin
        if (start) begin
          state_d    = S_LOAD;
          rom_addr_d = '0;
          score_d    = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // End of a note window: step the address or finish after the last slot
    if (adv) begin
      cur_note_d = '0;
      if (rom_addr_q == {ADDR_W{1'b1}}) begin
        state_d = S_DONE;
      end else begin
        state_d    = S_LOAD;
        rom_addr_d = rom_addr_q + ADDR_W'(1);
      end
    end

    if (abort) begin
      state_d       = S_IDLE;
      rom_addr_d    = '0;
      cur_note_d    = '0;
      hit_grade_d   = '0;
      grade_valid_d = 1'b0;
      hit_d         = 1'b0;
      score_d       = score_q;
    end

    if (running && (state_d == state_q)) begin
      pre_d      = tick ? '0 : pre_q + PRE_W'(1);
      tick_cnt_d = tick ? tick_cnt_q + CNT_W'(1) : tick_cnt_q;
    end

    note_en_d = (state_d == S_PLAY);
    busy_d    = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rom_addr_q    <= '0;
      cur_note_q    <= '0;
      note_en_q     <= 1'b0;
      hit_grade_q   <= '0;
      grade_valid_q <= 1'b0;
      score_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      hit_q         <= 1'b0;
      pre_q         <= '0;
      tick_cnt_q    <= '0;
      dur_q         <= '0;
    end else begin
      state_q       <= state_d;
      rom_addr_q    <= rom_addr_d;
      cur_note_q    <= cur_note_d;
      note_en_q     <= note_en_d;
      hit_grade_q   <= hit_grade_d;
      grade_valid_q <= grade_valid_d;
      score_q       <= score_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      hit_q         <= hit_d;
      pre_q         <= pre_d;
      tick_cnt_q    <= tick_cnt_d;
      dur_q         <= dur_d;
    end
  end

  assign rom_addr    = rom_addr_q;
  assign cur_note    = cur_note_q;
  assign note_en     = note_en_q;
  assign hit_grade   = hit_grade_q;
  assign grade_valid = grade_valid_q;
  assign score       = score_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_learn_step_scheduler.sv
// Scoreboard bench for learn_step_scheduler: a cycle-timeline model of each song predicts every grade pulse and the final score.
module tb_learn_step_scheduler;

  localparam int TD = 4;
  localparam int GT = 2;
  localparam int AW = 5;
  localparam int DW = 16;
  localparam int SW = 16;
  localparam int G_S = 0, G_A = 1, G_B = 2, G_C = 3, G_MISS = 4;

`ifdef LEARN_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, start, abort, key_valid;
  logic [3:0]    key_note, rom_note, cur_note;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_dur;
  logic          note_en, grade_valid, busy, done;
  logic [2:0]    hit_grade;
  logic [SW-1:0] score;

  logic [3:0]    note_mem [32];
  logic [DW-1:0] dur_mem  [32];

  assign rom_note = note_mem[rom_addr];
  assign rom_dur  = dur_mem[rom_addr];

  always #5 clk = ~clk;

  learn_step_scheduler #(
    .TICK_DIV (TD),
    .GAP_TICKS(GT),
    .ADDR_W   (AW),
    .DUR_W    (DW),
    .SCORE_W  (SW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .rom_addr   (rom_addr),
    .rom_note   (rom_note),
    .rom_dur    (rom_dur),
    .key_valid  (key_valid),
    .key_note   (key_note),
    .cur_note   (cur_note),
    .note_en    (note_en),
    .hit_grade  (hit_grade),
    .grade_valid(grade_valid),
    .score      (score),
    .busy       (busy),
    .done       (done)
  );

  typedef struct { int cyc; int grade; } exp_t;
  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int en_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every grade pulse must match the next predicted grade and cycle
  always @(negedge clk) begin
    exp_t e;
    if (note_en === 1'b1) en_cnt++;
    if (grade_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL grade_unexpected cyc=%0d got grade=%0d required no pulse", cyc, hit_grade);
      end else begin
        e = exp_q.pop_front();
        if ((hit_grade !== 3'(e.grade)) || (cyc != e.cyc)) begin
          errors++;
          $display("FAIL grade cyc=%0d got grade=%0d required grade=%0d at cyc=%0d",
                   cyc, hit_grade, e.grade, e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  function automatic int grade_of(input int c, input int d);
    int e, q;
    if (c >= d * TD) return G_C;
    e = c / TD;
    q = d / 4;
    if (e < q)     return G_S;
    if (e < 2 * q) return G_A;
    if (e < 3 * q) return G_B;
    return G_C;
  endfunction

  function automatic int pts_of(input int g);
    case (g)
      G_S:     return 3;
      G_A:     return 2;
      G_B:     return 1;
      default: return 0;
    endcase
  endfunction

  // One song from start pulse to DONE; mode_in<0 picks a random key pattern per note
  task automatic run_song(input bit rand_rom, input bit full, input int mode_in, input int wait_in,
                          output int sc);
    int n_notes, load_n, end_n, base, exp_en, exp_score;
    int ev_cyc[$];
    logic [3:0] ev_note[$];
    if (rand_rom) begin
      n_notes = full ? 32 : int'($urandom_range(1, 6));
      for (int i = 0; i < 32; i++) begin
        note_mem[i] = 4'($urandom_range(1, 15));
        dur_mem[i]  = DW'($urandom_range(0, 9));
      end
      if (!full) note_mem[n_notes] = 4'd0;
    end else begin
      n_notes = 0;
      while ((n_notes < 32) && (note_mem[n_notes] != 4'd0)) n_notes++;
    end

    @(negedge clk);
    base      = cyc;
    en_cnt    = 0;
    load_n    = 1;
    exp_en    = 0;
    exp_score = 0;
    for (int i = 0; i < n_notes; i++) begin
      int d, w, play_n, gap_end, mode, c1, c2, hit_c, g, wt;
      logic [3:0] nt;
      d       = (dur_mem[i] == '0) ? 1 : int'(dur_mem[i]);
      nt      = note_mem[i];
      w       = (d + GT) * TD;
      play_n  = load_n + 1;
      gap_end = play_n + w;
      exp_en += d * TD;
      mode    = (mode_in < 0) ? int'($urandom_range(0, 5)) : mode_in;
      c1      = int'($urandom_range(0, w - 2));
      c2      = int'($urandom_range(c1 + 1, w - 1));
      hit_c   = -1;
      case (mode)
        1: hit_c = c1;
        2: begin
          ev_cyc.push_back(play_n + c1);
          ev_note.push_back(4'((int'(nt) % 15) + 1));
          hit_c = c2;
        end
        3: hit_c = c1;
        4: hit_c = d * TD - 1;
        5: hit_c = w - 1;
        default: hit_c = -1;
      endcase
      if (hit_c >= 0) begin
        ev_cyc.push_back(play_n + hit_c);
        ev_note.push_back(nt);
        g = grade_of(hit_c, d);
        exp_q.push_back('{base + play_n + hit_c + 1, g});
        exp_score += pts_of(g);
        if (mode == 3) begin
          ev_cyc.push_back(play_n + c2);
          ev_note.push_back(nt);
        end
        load_n = gap_end;
      end else if (WAIT_EN) begin
        wt = (wait_in < 0) ? int'($urandom_range(0, 12)) : wait_in;
        ev_cyc.push_back(gap_end + wt);
        ev_note.push_back(nt);
        exp_q.push_back('{base + gap_end + wt + 1, G_C});
        load_n = gap_end + wt + 1;
      end else begin
        exp_q.push_back('{base + gap_end, G_MISS});
        load_n = gap_end;
      end
    end
    end_n = load_n + ((n_notes == 32) ? 0 : 1);

    for (int n = 0; n <= end_n + 2; n++) begin
      start     = (n == 0) || (n == 3);
      key_valid = 1'b0;
      key_note  = 4'd0;
      if ((ev_cyc.size() > 0) && (ev_cyc[0] == n)) begin
        key_valid = 1'b1;
        key_note  = ev_note.pop_front();
        void'(ev_cyc.pop_front());
      end
      @(negedge clk);
    end
    start     = 1'b0;
    key_valid = 1'b0;

    check("done_level", 32'(done), 32'd1);
    check("busy_in_done", 32'(busy), 32'd0);
    check("final_score", 32'(score), 32'(exp_score));
    check("note_en_cycles", 32'(en_cnt), 32'(exp_en));
    check("pending_grades", 32'(exp_q.size()), 32'd0);
    check("rom_addr_end", 32'(rom_addr), full ? 32'd31 : 32'(n_notes));
    check("cur_note_end", 32'(cur_note), 32'd0);
    exp_q.delete();
    sc = exp_score;
  endtask

  task automatic load_small_rom();
    for (int i = 0; i < 32; i++) begin
      note_mem[i] = 4'd0;
      dur_mem[i]  = '0;
    end
    note_mem[0] = 4'd1; dur_mem[0] = DW'(8);
    note_mem[1] = 4'd3; dur_mem[1] = DW'(4);
  endtask

  // Abort during note 2 PLAY, then an asynchronous reset during note 1 GAP
  task automatic abort_and_reset();
    int base;
    load_small_rom();
    @(negedge clk);
    base = cyc;
    exp_q.push_back('{base + 7, G_S});
    for (int n = 0; n < 46; n++) begin
      start     = (n == 0);
      key_valid = (n == 6);
      key_note  = (n == 6) ? 4'd1 : 4'd0;
      abort     = (n == 45);
      if (n == 44) begin
        check("note2_note_en", 32'(note_en), 32'd1);
        check("note2_cur_note", 32'(cur_note), 32'd3);
        check("note2_rom_addr", 32'(rom_addr), 32'd1);
      end
      @(negedge clk);
    end
    abort     = 1'b0;
    key_valid = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_note_en", 32'(note_en), 32'd0);
    check("abort_cur_note", 32'(cur_note), 32'd0);
    check("abort_rom_addr", 32'(rom_addr), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_score_held", 32'(score), 32'd3);

    base = cyc;
    exp_q.push_back('{base + 7, G_S});
    for (int n = 0; n < 36; n++) begin
      start     = (n == 0);
      key_valid = (n == 6);
      key_note  = (n == 6) ? 4'd1 : 4'd0;
      @(negedge clk);
    end
    start     = 1'b0;
    key_valid = 1'b0;
    check("gap_note_en", 32'(note_en), 32'd0);
    check("gap_busy", 32'(busy), 32'd1);
    check("gap_score", 32'(score), 32'd3);
    #2 reset = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    check("rst_cur_note", 32'(cur_note), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_grade", {29'd0, grade_valid, hit_grade}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check("pending_after_reset", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int sc;
    reset     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    key_valid = 1'b0;
    key_note  = 4'd0;
    load_small_rom();
    #6;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_note_en", 32'(note_en), 32'd0);
    check("reset_score", 32'(score), 32'd0);
    check("reset_grade", {29'd0, grade_valid, hit_grade}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // No keys on the small ROM; WAIT build parks 1000 cycles before the key
    run_song(1'b0, 1'b0, 0, 1000, sc);
    abort_and_reset();

    for (int s = 0; s < 14; s++) run_song(1'b1, (s == 5) || (s == 11), -1, -1, sc);

    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("done_abort_done", 32'(done), 32'd0);
    check("done_abort_busy", 32'(busy), 32'd0);
    check("done_abort_score", 32'(score), 32'(sc));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/learn_step_scheduler.md
Name: learn_step_scheduler

Overview:
- Sequencer for learning-play mode. Steps a song ROM address through each note, times each note window and the silent gap after it, and enables the buzzer and LED guide for the current note.
- Grades each player key hit against the note window and accumulates a saturating score.
- Sits between the song ROM, the key decoder, and the buzzer/LED drivers. Replaces free-running index stepping with one clocked FSM.

Parameters:
- TICK_DIV, 100000, clk cycles per timing tick (1 ms at 100 MHz).
- GAP_TICKS, 100, ticks of silence after each note window.
- ADDR_W, 5, ROM address width; song length up to 2^ADDR_W notes.
- DUR_W, 16, width of ROM note duration, in ticks.
- SCORE_W, 16, score accumulator width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- start  in  1  single-cycle pulse; begins the song at address 0
- abort  in  1  single-cycle pulse; returns to IDLE
- rom_addr  out  ADDR_W  song ROM address (ROM read is combinational)
- rom_note  in  4  note code at rom_addr; 4'd0 = end-of-song marker
- rom_dur  in  DUR_W  note window length in ticks
- key_valid  in  1  single-cycle pulse, debounced key press
- key_note  in  4  note code of the pressed key
- cur_note  out  4  note being guided; 0 outside PLAY/GAP/WAIT
- note_en  out  1  buzzer/LED enable; high only in PLAY
- hit_grade  out  3  S=000, A=001, B=010, C=011, Miss=100
- grade_valid  out  1  single-cycle pulse qualifying hit_grade
- score  out  SCORE_W  accumulated points
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  level; high in DONE

Behaviour:
- Reset values (asynchronous): state=IDLE, rom_addr=0, cur_note=0, note_en=0, hit_grade=0, grade_valid=0, score=0, busy=0, done=0, prescaler=0, tick counter=0, hit flag=0.
- States: IDLE, LOAD, PLAY, GAP, WAIT (only with the optional feature), DONE.
- Prescaler:
  - Runs only in PLAY, GAP and WAIT.
  - Clears on every state entry.
  - Emits a tick when it reaches TICK_DIV-1.
  - Tick counter counts ticks and clears on every state entry.
- IDLE:
  - start → LOAD; rom_addr=0, score=0.
  - All other inputs are ignored.
- LOAD (1 cycle):
  - Registers dur_r = max(rom_dur, 1) and cur_note = rom_note.
  - Clears the hit flag.
  - If rom_note==0 → DONE; otherwise → PLAY.
- PLAY:
  - note_en=1.
  - Leaves on the tick that brings the counter to dur_r → GAP.
- GAP:
  - note_en=0.
  - After GAP_TICKS ticks:
    - If no hit recorded: one grade_valid pulse with Miss.
    - Then, if rom_addr == 2^ADDR_W-1 → DONE; else rom_addr+1 → LOAD.
- DONE:
  - done=1, busy=0; hold score.
  - start → LOAD (score clears); abort → IDLE.
- Grading (registered; grade_valid pulses on the cycle after key_valid):
  - Applies only on key_valid with key_note==cur_note, hit flag clear, state in PLAY, GAP or WAIT. Sets the hit flag.
  - q = dur_r >> 2; e = tick count in PLAY.
  - PLAY: e<q → S; e<2q → A; e<3q → B; else → C.
  - GAP or WAIT: C.
  - Points: S=3, A=2, B=1, C=0, Miss=0. score saturates at all-ones.
- Ignored key events:
  - Wrong key_note: no grade, no score change.
  - Repeat correct key after the hit flag is set: ignored.
- Simultaneous events:
  - Correct key on the same cycle as the PLAY→GAP tick: graded with PLAY thresholds.
  - Correct key on the final GAP tick: counts as C; no Miss pulse is emitted.
- abort in any state → IDLE on the next edge. Outputs return to reset values except score, which holds.
- start while busy: ignored.
- Reset mid-song: immediate return to reset values.

Optional Feature:
- Macro: LEARN_WAIT_EN.
- Defined:
  - When GAP ends with no hit, go to WAIT instead of emitting Miss.
  - WAIT: note_en=0, cur_note held, rom_addr held.
  - First correct key grades C, then advances exactly as GAP-end does. No Miss is ever emitted.
  - abort still exits WAIT.
- Undefined: the WAIT state and its logic are absent; behaviour is as described above.

Test Plan:
- Bench uses TICK_DIV=4, GAP_TICKS=2. ROM = {note 1 dur 8, note 3 dur 4, note 0}. Pulse start, no keys → two Miss pulses; note_en high 32 then 16 cycles; done=1; score=0.
- Same ROM, key_note=1 at PLAY tick 1 (e=1 < q=2) → grade S, score=3. Key_note=3 at tick 3 of note 2 (q=1, e=3 ≥ 3q) → grade C, score stays 3.
- Wrong key 5 during note 1, then correct key at e=3 → exactly one grade_valid, grade A, score=2.
- Correct key during GAP → grade C; no Miss at GAP end; rom_addr advances.
- abort mid-PLAY → IDLE next cycle, note_en=0, score held. Assert reset mid-GAP → all outputs return to reset values asynchronously.
- With LEARN_WAIT_EN defined and no key on note 1 → FSM stays in WAIT 1000 cycles with rom_addr=0. Key 1 → grade C, then LOAD of address 1.
